hazard_scoreboard: RTL and testbench

//  Parametrised successor to the ID-stage load-use stall check. Tracks up to MAX_OUTSTANDING
//  in-flight long-latency writes (loads, mul/div): fixed-latency via countdown, variable-latency
//  via writeback release. Stalls the ID stage on RAW/WAW hazards or a full table.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_if.sv | 53 +++++
 rtl/hazard_sb_entry.sv | 71 +++++++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: default widths, table entry layout, stall causes.
// Optional build macro HAZARD_PERF_EN is consumed by hazard_scoreboard and its interface.
package hazard_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_LAT_W      = 3;

  // Reference layout of one table slot at the default widths.
  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic [DEFAULT_LAT_W-1:0]      cnt;
    logic                          fixed;
    logic                          young;
  } sb_entry_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_RAW,
    CAUSE_WAW,
    CAUSE_FULL
  } stall_cause_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/issue/writeback bundle between the pipeline (master) and the hazard scoreboard (slave).
// With HAZARD_PERF_EN defined the bundle also carries the performance counters.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W      = hazard_pkg::DEFAULT_REG_ADDR_W,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LAT_W           = hazard_pkg::DEFAULT_LAT_W
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_we;
  logic                  id_long;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_long;
  logic [LAT_W-1:0]      issue_lat;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  flush_ex;
  logic                  stall;
  logic [CNT_W-1:0]      busy_cnt;
  logic [NUM_REGS-1:0]   pending_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0]           perf_stall_cnt;
  logic [15:0]           perf_full_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_long,
    output issue_valid, issue_rd, issue_long, issue_lat,
    output wb_valid, wb_rd, flush_ex,
    input  stall, busy_cnt, pending_mask
`ifdef HAZARD_PERF_EN
    , input perf_stall_cnt, perf_full_cnt
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_long,
    input  issue_valid, issue_rd, issue_long, issue_lat,
    input  wb_valid, wb_rd, flush_ex,
    output stall, busy_cnt, pending_mask
`ifdef HAZARD_PERF_EN
    , output perf_stall_cnt, perf_full_cnt
`endif
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: holds a pending destination, counts down fixed latencies,
// releases on writeback or flush, and reports register matches for the ID stage.
module hazard_sb_entry #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc,
  input  logic [REG_ADDR_W-1:0] alloc_rd,
  input  logic [LAT_W-1:0]      alloc_lat,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_release,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  valid,
  output logic                  wb_hit,
  output logic                  freeing,
  output logic                  match_rs1,
  output logic                  match_rs2,
  output logic                  match_rd,
  output logic [REG_ADDR_W-1:0] ent_rd
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [LAT_W-1:0]      cnt;
    logic                  fixed;
    logic                  young;
  } entry_t;

  entry_t q;
  logic   count_done;

  assign count_done = q.fixed && (q.cnt == LAT_W'(1));
  assign wb_hit     = q.valid && !q.fixed && wb_valid && (q.rd == wb_rd);
  // wb_release comes from the top's lowest-index pick among all wb_hit slots.
  assign freeing    = q.valid && ((flush && q.young) || wb_release || count_done);

  assign valid     = q.valid;
  assign ent_rd    = q.rd;
  assign match_rs1 = q.valid && (q.rd == rs1);
  assign match_rs2 = q.valid && (q.rd == rs2);
  assign match_rd  = q.valid && (q.rd == rd);

  // NOTE: state registers use non-blocking assignments so every slot samples the
  // same pre-edge table; the whole slot is reset because valid gates everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (alloc) begin
      q.valid <= 1'b1;
      q.rd    <= alloc_rd;
      q.cnt   <= alloc_lat;
      q.fixed <= (alloc_lat != '0);
      q.young <= 1'b1;
    end else begin
      q.young <= 1'b0;
      if (freeing) begin
        q.valid <= 1'b0;
      end else if (q.valid && q.fixed) begin
        q.cnt <= q.cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight long-latency writes and stalls on RAW/WAW/full.
// Define HAZARD_PERF_EN to add saturating stall and full-stall performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W      = DEFAULT_REG_ADDR_W,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LAT_W           = DEFAULT_LAT_W
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_OUTSTANDING-1:0] valid;
  logic [MAX_OUTSTANDING-1:0] freeing;
  logic [MAX_OUTSTANDING-1:0] wb_hit;
  logic [MAX_OUTSTANDING-1:0] wb_release;
  logic [MAX_OUTSTANDING-1:0] avail;
  logic [MAX_OUTSTANDING-1:0] alloc_sel;
  logic [MAX_OUTSTANDING-1:0] m_rs1;
  logic [MAX_OUTSTANDING-1:0] m_rs2;
  logic [MAX_OUTSTANDING-1:0] m_rd;
  logic [REG_ADDR_W-1:0]      ent_rd [MAX_OUTSTANDING];

  logic                  alloc_req;
  logic [CNT_W-1:0]      busy_cnt;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  raw_haz;
  logic                  waw_haz;
  logic                  full_haz;
  stall_cause_t          cause;

  assign alloc_req = sb.issue_valid && sb.issue_long && (sb.issue_rd != '0);

  // Lowest set bit wins both for writeback release and for slot allocation; a slot
  // freeing this cycle counts as available, and its allocation overrides the free.
  assign wb_release = wb_hit & (~wb_hit + MAX_OUTSTANDING'(1));
  assign avail      = ~valid | freeing;
  assign alloc_sel  = alloc_req ? (avail & (~avail + MAX_OUTSTANDING'(1))) : '0;

  for (genvar i = 0; i < MAX_OUTSTANDING; i++) begin : g_slot
    hazard_sb_entry #(
      .REG_ADDR_W (REG_ADDR_W),
      .LAT_W      (LAT_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .alloc      (alloc_sel[i]),
      .alloc_rd   (sb.issue_rd),
      .alloc_lat  (sb.issue_lat),
      .flush      (sb.flush_ex),
      .wb_valid   (sb.wb_valid),
      .wb_rd      (sb.wb_rd),
      .wb_release (wb_release[i]),
      .rs1        (sb.id_rs1),
      .rs2        (sb.id_rs2),
      .rd         (sb.id_rd),
      .valid      (valid[i]),
      .wb_hit     (wb_hit[i]),
      .freeing    (freeing[i]),
      .match_rs1  (m_rs1[i]),
      .match_rs2  (m_rs2[i]),
      .match_rd   (m_rd[i]),
      .ent_rd     (ent_rd[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy_cnt     = '0;
    pending_mask = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      busy_cnt = busy_cnt + CNT_W'(valid[i]);
      if (valid[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_comb begin
    raw_haz  = (sb.id_rs1_used && (sb.id_rs1 != '0) && (|m_rs1) &&
                !(sb.wb_valid && (sb.wb_rd == sb.id_rs1))) ||
               (sb.id_rs2_used && (sb.id_rs2 != '0) && (|m_rs2) &&
                !(sb.wb_valid && (sb.wb_rd == sb.id_rs2)));
    waw_haz  = sb.id_rd_we && (sb.id_rd != '0) && (|m_rd) &&
               !(sb.wb_valid && (sb.wb_rd == sb.id_rd));
    full_haz = sb.id_long && (busy_cnt == CNT_W'(MAX_OUTSTANDING)) && !(|freeing);
    cause    = CAUSE_NONE;
    if (raw_haz)       cause = CAUSE_RAW;
    else if (waw_haz)  cause = CAUSE_WAW;
    else if (full_haz) cause = CAUSE_FULL;
  end

  assign sb.stall        = (cause != CAUSE_NONE);
  assign sb.busy_cnt     = busy_cnt;
  assign sb.pending_mask = pending_mask;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_full_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (sb.stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (full_haz && (perf_full_cnt != '1))  perf_full_cnt  <= perf_full_cnt + 16'd1;
    end
  end

  assign sb.perf_stall_cnt = perf_stall_cnt;
  assign sb.perf_full_cnt  = perf_full_cnt;
`endif

  // Issuing a long op into a full table is a pipeline protocol error; the op is dropped.
  a_no_alloc_when_full : assert property (@(posedge clk) disable iff (rst)
    !(alloc_req && !(|avail)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: load-use, variable latency, full table,
// flush, x0 handling, WAW, fixed countdown and asynchronous reset.
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W      = 5;
  localparam int NUM_REGS        = 32;
  localparam int MAX_OUTSTANDING = 4;
  localparam int LAT_W           = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard_scoreboard_if #(
    .REG_ADDR_W      (REG_ADDR_W),
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .LAT_W           (LAT_W)
  ) sb_if ();

  hazard_scoreboard #(
    .REG_ADDR_W      (REG_ADDR_W),
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .LAT_W           (LAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sb_if.id_rs1      = '0;
    sb_if.id_rs2      = '0;
    sb_if.id_rs1_used = 1'b0;
    sb_if.id_rs2_used = 1'b0;
    sb_if.id_rd       = '0;
    sb_if.id_rd_we    = 1'b0;
    sb_if.id_long     = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_rd    = '0;
    sb_if.issue_long  = 1'b0;
    sb_if.issue_lat   = '0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_rd       = '0;
    sb_if.flush_ex    = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [REG_ADDR_W-1:0] rd, input logic [LAT_W-1:0] lat);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_long  = 1'b1;
    sb_if.issue_rd    = rd;
    sb_if.issue_lat   = lat;
  endtask

  task automatic writeback(input logic [REG_ADDR_W-1:0] rd);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = rd;
  endtask

  task automatic read_rs1(input logic [REG_ADDR_W-1:0] r);
    sb_if.id_rs1      = r;
    sb_if.id_rs1_used = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(sb_if.stall), 32'd0);
    check("reset_busy", 32'(sb_if.busy_cnt), 32'd0);
    check("reset_mask", sb_if.pending_mask, 32'h0);
    rst = 1'b0;

    // 1: load x5 with latency 1, dependent instruction in ID next cycle
    tick();
    issue(5'd5, 3'd1);
    #1 check("t1_issue_no_stall", 32'(sb_if.stall), 32'd0);
    tick();
    idle();
    read_rs1(5'd5);
    #1 check("t1_load_use_stall", 32'(sb_if.stall), 32'd1);
    check("t1_mask_set", sb_if.pending_mask, 32'h0000_0020);
    check("t1_busy_1", 32'(sb_if.busy_cnt), 32'd1);
    tick();
    check("t1_stall_released", 32'(sb_if.stall), 32'd0);
    check("t1_mask_clear", sb_if.pending_mask, 32'h0);

    // 2: variable-latency div x7, held until writeback, bypassed in the writeback cycle
    idle();
    issue(5'd7, 3'd0);
    tick();
    idle();
    read_rs1(5'd7);
    #1 check("t2_stall_c1", 32'(sb_if.stall), 32'd1);
    tick();
    check("t2_stall_c2", 32'(sb_if.stall), 32'd1);
    writeback(5'd7);
    #1 check("t2_wb_bypass", 32'(sb_if.stall), 32'd0);
    tick();
    idle();
    read_rs1(5'd7);
    #1 check("t2_after_wb_stall", 32'(sb_if.stall), 32'd0);
    check("t2_after_wb_busy", 32'(sb_if.busy_cnt), 32'd0);

    // 3: fill the table with x1..x4, long op in ID stalls on FULL until a slot frees
    idle();
    for (int r = 1; r <= 4; r++) begin
      issue(REG_ADDR_W'(r), 3'd0);
      tick();
    end
    idle();
    sb_if.id_long = 1'b1;
    #1 check("t3_full_stall", 32'(sb_if.stall), 32'd1);
    check("t3_busy_4", 32'(sb_if.busy_cnt), 32'd4);
    check("t3_mask_full", sb_if.pending_mask, 32'h0000_001E);
    writeback(5'd2);
    #1 check("t3_full_freeing", 32'(sb_if.stall), 32'd0);
    tick();
    sb_if.wb_valid = 1'b0;
    #1 check("t3_busy_3", 32'(sb_if.busy_cnt), 32'd3);
    check("t3_mask_after_wb", sb_if.pending_mask, 32'h0000_001A);
    check("t3_not_full_stall", 32'(sb_if.stall), 32'd0);
    idle();
    writeback(5'd1); tick();
    writeback(5'd3); tick();
    writeback(5'd4); tick();
    idle();
    #1 check("t3_drained", 32'(sb_if.busy_cnt), 32'd0);

    // 4: flush kills the entry allocated in the previous cycle
    issue(5'd9, 3'd3);
    tick();
    idle();
    sb_if.flush_ex = 1'b1;
    #1 check("t4_busy_before_flush", 32'(sb_if.busy_cnt), 32'd1);
    tick();
    idle();
    read_rs1(5'd9);
    #1 check("t4_busy_after_flush", 32'(sb_if.busy_cnt), 32'd0);
    check("t4_no_stall_x9", 32'(sb_if.stall), 32'd0);

    // 4b: allocation in the flush cycle survives and reuses the freed slot
    idle();
    issue(5'd10, 3'd0);
    tick();
    idle();
    sb_if.flush_ex = 1'b1;
    issue(5'd11, 3'd0);
    tick();
    idle();
    #1 check("t4b_busy", 32'(sb_if.busy_cnt), 32'd1);
    check("t4b_mask", sb_if.pending_mask, 32'h0000_0800);
    writeback(5'd11);
    tick();
    idle();

    // 5: x0 never stalls or allocates; WAW on a pending destination stalls
    issue(5'd3, 3'd0);
    tick();
    idle();
    read_rs1(5'd0);
    sb_if.id_rd    = 5'd0;
    sb_if.id_rd_we = 1'b1;
    #1 check("t5_x0_no_stall", 32'(sb_if.stall), 32'd0);
    issue(5'd0, 3'd0);
    tick();
    idle();
    #1 check("t5_x0_no_alloc", 32'(sb_if.busy_cnt), 32'd1);
    sb_if.id_rs2      = 5'd3;
    sb_if.id_rs2_used = 1'b0;
    #1 check("t5_unused_rs2", 32'(sb_if.stall), 32'd0);
    sb_if.id_rd    = 5'd3;
    sb_if.id_rd_we = 1'b1;
    #1 check("t5_waw_stall", 32'(sb_if.stall), 32'd1);
    idle();
    writeback(5'd3);
    tick();
    idle();

    // 7: fixed latency 3 counts down three cycles and ignores writebacks
    issue(5'd12, 3'd3);
    tick();
    idle();
    writeback(5'd12);
    tick();
    idle();
    #1 check("t7_fixed_ignores_wb", 32'(sb_if.busy_cnt), 32'd1);
    check("t7_mask", sb_if.pending_mask, 32'h0000_1000);
    tick();
    check("t7_still_pending", 32'(sb_if.busy_cnt), 32'd1);
    tick();
    check("t7_freed", 32'(sb_if.busy_cnt), 32'd0);

    // 6: asynchronous reset with three valid entries
    for (int r = 4; r <= 6; r++) begin
      issue(REG_ADDR_W'(r), 3'd0);
      tick();
    end
    idle();
    sb_if.id_rs2      = 5'd6;
    sb_if.id_rs2_used = 1'b1;
    #1 check("t6_rs2_stall", 32'(sb_if.stall), 32'd1);
    check("t6_busy_3", 32'(sb_if.busy_cnt), 32'd3);
    #2 rst = 1'b1;
    #1 check("t6_rst_stall", 32'(sb_if.stall), 32'd0);
    check("t6_rst_busy", 32'(sb_if.busy_cnt), 32'd0);
    check("t6_rst_mask", sb_if.pending_mask, 32'h0);
`ifdef HAZARD_PERF_EN
    check("t6_rst_perf", sb_if.perf_stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    idle();
    tick();
    check("t6_post_reset_busy", 32'(sb_if.busy_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
